// File: rtl/mux_scan.sv
// mux_scan: registered N-channel by W-bit selector with direct, auto-scan,
// hold and single-sweep modes, a programmable per-channel dwell time and a
// registered channel index with wrap/done status.
module mux_scan #(
  parameter  int N  = 16,
  parameter  int W  = 1,
  parameter  int DW = 8,
  localparam int SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  w,
  input  logic [SW-1:0]   s,
  input  logic [1:0]      mode,
  input  logic [DW-1:0]   dwell,
  input  logic            load,
  output logic [W-1:0]    f,
  output logic [SW-1:0]   ch,
  output logic            valid,
  output logic            wrap,
  output logic            done
);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_SWEEP  = 2'b11
  } mode_e;

  typedef enum logic {
    SWEEP_RUN,
    SWEEP_DONE
  } sweep_e;

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  // Unpacked view of the packed channel bus.
  logic [W-1:0] chan [N];

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign chan[k] = w[k*W +: W];
  end

  function automatic logic in_range(input logic [SW-1:0] x);
    return int'(x) < N;
  endfunction

  mode_e          mode_in;
  mode_e          mode_q;
  sweep_e         state_q;
  sweep_e         state_d;
  sweep_e         state_eff;
  logic [DW-1:0]  cnt_q;
  logic [DW-1:0]  cnt_d;
  logic [DW-1:0]  cnt_eff;
  logic [SW-1:0]  sel;
  logic [SW-1:0]  next_ch;
  logic [SW-1:0]  load_ch;
  logic [W-1:0]   f_d;
  logic           mode_chg;
  logic           step;
  logic           at_last;
  logic           hold;
  logic           wrap_d;
  logic           done_d;

  assign mode_in = mode_e'(mode);

  // Channel selection, dwell counting and sweep FSM next state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    mode_chg  = (mode_in != mode_q);
    cnt_eff   = mode_chg ? '0 : cnt_q;
    state_eff = mode_chg ? SWEEP_RUN : state_q;
    step      = (cnt_eff >= dwell);
    at_last   = (ch == LAST);
    // A leftover out-of-range index from direct mode also steps to 0.
    next_ch   = (at_last || !in_range(ch)) ? '0 : ch + SW'(1);
    load_ch   = in_range(s) ? s : '0;

    sel     = ch;
    cnt_d   = cnt_q;
    state_d = state_q;
    done_d  = done;
    wrap_d  = 1'b0;
    hold    = 1'b0;

    unique case (mode_in)
      MODE_DIRECT: begin
        sel     = s;
        cnt_d   = '0;
        state_d = SWEEP_RUN;
        done_d  = 1'b0;
      end

      MODE_HOLD: begin
        hold    = 1'b1;
        cnt_d   = cnt_eff;
        state_d = state_eff;
        done_d  = mode_chg ? 1'b0 : done;
      end

      MODE_SCAN, MODE_SWEEP: begin
        state_d = SWEEP_RUN;
        done_d  = 1'b0;
        if (load) begin
          sel   = load_ch;
          cnt_d = '0;
        end else if (mode_in == MODE_SWEEP && state_eff == SWEEP_DONE) begin
          // Parked on the last channel, still resampling it.
          sel     = LAST;
          cnt_d   = cnt_q;
          state_d = SWEEP_DONE;
          done_d  = 1'b1;
        end else if (step) begin
          cnt_d = '0;
          if (mode_in == MODE_SWEEP && at_last) begin
            sel     = LAST;
            state_d = SWEEP_DONE;
            done_d  = 1'b1;
          end else begin
            sel    = next_ch;
            wrap_d = at_last;
          end
        end else begin
          sel   = ch;
          cnt_d = mode_chg ? '0 : cnt_q + DW'(1);
        end
      end

      default: begin
        sel = ch;
      end
    endcase

    f_d = in_range(sel) ? chan[sel] : '0;
  end

  // State and output registers; hold mode freezes f and ch.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample the values
    // from before this edge, regardless of statement order.
    if (rst) begin
      f       <= '0;
      ch      <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
      done    <= 1'b0;
      cnt_q   <= '0;
      state_q <= SWEEP_RUN;
      mode_q  <= MODE_DIRECT;
    end else begin
      valid   <= 1'b1;
      wrap    <= wrap_d;
      done    <= done_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      mode_q  <= mode_in;
      if (!hold) begin
        ch <= sel;
        f  <= f_d;
      end
    end
  end

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N-channel by W-bit selector: the clocked successor to the team's 16:1 single-bit tree multiplexer. It adds direct, auto-scan, hold and single-sweep modes, a programmable dwell time per channel, and a registered channel index with wrap/done status. It sits between multi-channel sample sources and a single downstream consumer that needs the channels time-multiplexed onto one bus.

## Interface
- N, default 16: number of channels, 2..256, not restricted to a power of two.
- W, default 1: bits per channel.
- DW, default 8: dwell counter width.
- SW, derived as max(1, clog2(N)): select and channel index width. Not user-overridden.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- w  input  N*W  packed channel data; channel k occupies bits [k*W +: W].
- s  input  SW  direct-mode select; load target in scan/sweep modes.
- mode  input  2  00 direct, 01 auto-scan, 10 hold, 11 single sweep.
- dwell  input  DW  a channel is held for dwell+1 cycles in scan/sweep.
- load  input  1  in modes 01/11: jump to channel s and restart dwell. Ignored in modes 00/10.
- f  output  W  registered selected data.
- ch  output  SW  registered channel index, aligned with f.
- valid  output  1  high from the first edge after rst is deasserted.
- wrap  output  1  one-cycle pulse when scan wraps from N-1 to 0.
- done  output  1  sweep finished; level signal.

## Operation
- Each cycle, combinational sel is chosen. On the edge: ch<=sel, f<=w[sel] (f is resampled every cycle, except in hold).
- Priority, highest first: rst, mode change, load, dwell step.
- Mode 00 (direct): sel=s. If s>=N: f<=0 and ch<=s. cnt is held at 0.
- Mode 01 (auto-scan):
  - If cnt>=dwell: cnt<=0 and sel=(ch==N-1)?0:ch+1. Otherwise sel=ch and cnt<=cnt+1.
  - The N-1 to 0 step sets wrap<=1 for one cycle, coincident with ch=0.
  - `>=` makes a dwell reduction mid-count take effect without overrun.
- Mode 10 (hold): f, ch and cnt are frozen. Input w is ignored.
- Mode 11 (sweep): FSM with states RUN and DONE.
  - RUN: steps as in mode 01. When ch==N-1 and cnt>=dwell, go to DONE: done<=1, ch stays N-1, no wrap pulse.
  - DONE: sel=N-1, f keeps sampling w[N-1], cnt is held.
  - load in either state: go to RUN with ch<=s, cnt<=0, done<=0.
- load in modes 01/11: sel=s (s>=N gives sel=0), cnt<=0. No wrap pulse.
- Mode change (mode differs from the previous cycle's mode): cnt<=0, done<=0, FSM<=RUN. ch continues from its current value; that cycle's sel follows the new mode's rule with cnt treated as 0.
- Entering mode 11 without load sweeps from the current ch to N-1.
- If ch>=N on entering scan/sweep (left over from an out-of-range direct select): the next step goes to 0.

## Timing
- Reset values: f=0, ch=0, valid=0, wrap=0, done=0, cnt=0, FSM=RUN, stored previous mode=00.
- rst asserted mid-scan/sweep takes effect at the next edge and overrides load and mode.
- Direct mode: 1-cycle latency from s/w to f/ch.
- Scan: each channel appears on ch for exactly dwell+1 consecutive cycles. dwell=0 steps every cycle.
- wrap is high only in the single cycle where ch first shows 0 after N-1.
- done rises in the cycle after ch=N-1 has completed dwell+1 cycles, and remains high until load, mode change or rst.
- N=2: scan alternates 0,1,0,1 with a wrap pulse on every return to 0.

## Test plan
- Reset, N=16, W=4, w[k]=k: assert rst for 2 cycles -> f=0, ch=0, valid=0. Release -> valid=1 after the next edge.
- Direct mode, s=5 -> next cycle f=4'h5, ch=5. Change s to 15 -> f=4'hF one cycle later. N=12 with s=13 -> f=0, ch=13.
- Scan, dwell=2 -> ch sequence 0,0,0,1,1,1,...,15,15,15,0. wrap=1 only on the first cycle of ch=0 after 15.
- Scan with load: load=1, s=9 mid-dwell on ch=3 -> ch=9 next cycle, held 3 cycles, no wrap pulse.
- Sweep, dwell=0: load with s=13 -> ch 13,14,15, then done=1 with ch stuck at 15. load with s=0 -> done=0, sweep restarts.
- Hold: switch to mode 10 at ch=7 and toggle w -> f and ch unchanged. Return to mode 01 -> cnt restarts, ch=7 held for dwell+1 cycles. Assert rst mid-hold -> all outputs reset.
